sw_outarb: RTL and testbench
============================

// Module: sw_outarb
//
// PURPOSE
//   Output-port arbiter for the 4-port switch. It arbitrates among four input
//   ports requesting this output and forwards the winner's data word
//   downstream with a valid/ready handshake. It returns a one-cycle ack to the
//   granted input only.
//   Its four ack outputs feed ackor, which merges them into the single ack
//   seen by the input side. This block therefore guarantees that its acks are
//   one-hot or all-zero.
//
// PARAMETERS
//   DW     32   data word width of dat0..dat3 and out_dat
//
// PORTS
//   clk       in   1    clock; all state updates on posedge
//   rst       in   1    reset; asynchronous, active-high
//   req0..3   in   1    request from input port i; held high until ack_i seen
//   dat0..3   in   DW   data from input port i; stable while req_i high
//   ack0..3   out  1    one-cycle pulse: word from input i accepted downstream
//   out_vld   out  1    out_dat holds a valid word
//   out_dat   out  DW   forwarded word (registered)
//   out_rdy   in   1    downstream can accept; transfer when out_vld&out_rdy at posedge
//
// BEHAVIOUR
//   Reset (async, immediate)
//   - state=IDLE; last=3, so port 0 has first priority.
//   - ack0..3=0, out_vld=0, out_dat=0.
//   FSM states: IDLE, SEND, ACK.
//   - IDLE: if any req_i is high at posedge, the winner g is the first requester
//     in round-robin order last+1, last+2, ... (mod 4).
//     On that same edge: out_dat<=dat_g, out_vld<=1, grant register<=g,
//     state<=SEND. No request: stay IDLE, outputs unchanged.
//   - SEND: out_vld=1, and out_dat/grant are frozen.
//     At a posedge with out_rdy=1: out_vld<=0, ack_g<=1, last<=g, state<=ACK.
//     With out_rdy=0: hold indefinitely; there is no timeout.
//   - ACK: ack_g=1 for exactly this one cycle.
//     Next edge: ack_g<=0, state<=IDLE.
//   Timing
//   - Latency: req sampled at edge k -> out_vld high after edge k.
//   - With out_rdy held high, ack is high during the cycle after edge k+1.
//   - Minimum 3 cycles per transfer (IDLE, SEND, ACK), so throughput is at
//     most 1 word per 3 cycles.
//   Requester rule
//   - The requester drops req_i at the edge where it samples ack_i=1, i.e. the
//     ACK->IDLE edge.
//   - The arbiter therefore sees a fresh req only from the IDLE cycle onward.
//   Boundary conditions
//   - Simultaneous requests: strict round-robin from last+1. The port just
//     served has lowest priority next.
//   - req_g dropped during SEND: the transfer still completes, because data is
//     latched, and ack_g still pulses.
//   - req_i of a non-granted port changing during SEND/ACK: ignored.
//   - Ack invariant: at most one ack_i high in any cycle, and no ack without a
//     preceding out_vld&out_rdy handshake.
//   - out_rdy high in IDLE or ACK: no effect.
//   - Reset mid-SEND or mid-ACK: transfer aborted, no ack issued, all outputs
//     go to 0 immediately.
//   - After reset deasserts, arbitration restarts with port 0 first.
//   - last wraps 3 -> 0.
//
// TESTING
//   1. Reset, then req0=1 with dat0=32'hA5A5_0000, out_rdy=1
//      -> out_vld=1 with out_dat=A5A5_0000 for 1 cycle
//      -> ack0 pulses 1 cycle
//      -> ack1..3 stay 0.
//   2. req0..3 all high from reset, each dat_i=i, out_rdy=1
//      -> grants in order 0,1,2,3,0 (each port re-requests after its ack)
//      -> out_dat sequence 0,1,2,3,0.
//   3. req2=1, out_rdy=0 for 5 cycles, then 1
//      -> out_vld and out_dat held for all 5 cycles
//      -> ack2 only in the cycle after out_rdy is sampled high.
//   4. req1 drops during SEND -> ack1 still pulses once and the word is
//      delivered.
//   5. Assert rst during SEND
//      -> out_vld and all acks are 0 at once, with no ack afterwards
//      -> after release with req3=1, port 3 is granted (last=3 -> search 0..3).
//   6. Random req/out_rdy over 1000 cycles, with a checker on every cycle:
//      - acks one-hot or zero, so the ackor output equals the OR of the acks;
//      - every ack matches the granted port of the last handshake;
//      - no port starves longer than 4 transfers.

Source files
------------

// File: rtl/sw_outarb_if.sv
// Handshake bundle between the four input ports, the output arbiter and the downstream sink.
interface sw_outarb_if #(parameter int DW = 32);
   logic          req0, req1, req2, req3;
   logic [DW-1:0] dat0, dat1, dat2, dat3;
   logic          ack0, ack1, ack2, ack3;
   logic          out_vld;
   logic [DW-1:0] out_dat;
   logic          out_rdy;

   modport master (
      input  req0, req1, req2, req3,
      input  dat0, dat1, dat2, dat3,
      input  out_rdy,
      output ack0, ack1, ack2, ack3,
      output out_vld, out_dat
   );

   modport slave (
      output req0, req1, req2, req3,
      output dat0, dat1, dat2, dat3,
      output out_rdy,
      input  ack0, ack1, ack2, ack3,
      input  out_vld, out_dat
   );
endinterface

// File: rtl/sw_outarb.sv
// Round-robin output arbiter: latches the winner's word, waits for the sink, then pulses a one-hot ack.
// One word per three cycles at best (IDLE, SEND, ACK); SEND holds indefinitely while out_rdy is low.
module sw_outarb #(
   parameter int DW = 32
) (
   input  logic        clk,
   input  logic        rst,
   sw_outarb_if.master bus
);
   typedef enum logic [1:0] {IDLE, SEND, ACK} state_t;

   state_t        state_q, state_d;
   logic [1:0]    last_q, last_d;
   logic [1:0]    grant_q, grant_d;
   logic [3:0]    ack_q, ack_d;
   logic          out_vld_q, out_vld_d;
   logic [DW-1:0] out_dat_q, out_dat_d;

   logic [3:0]    req_v;
   logic [DW-1:0] dat_v [4];
   logic [1:0]    win;
   logic          found;

   assign req_v    = {bus.req3, bus.req2, bus.req1, bus.req0};
   assign dat_v[0] = bus.dat0;
   assign dat_v[1] = bus.dat1;
   assign dat_v[2] = bus.dat2;
   assign dat_v[3] = bus.dat3;

   // Search starts one past the last served port, so that port ranks last.
   always_comb begin
      win   = last_q;
      found = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         if (!found && req_v[last_q + 2'(i)]) begin
            win   = last_q + 2'(i);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      grant_d   = grant_q;
      ack_d     = '0;
      out_vld_d = out_vld_q;
      out_dat_d = out_dat_q;
      case (state_q)
         IDLE: begin
            if (|req_v) begin
               out_dat_d = dat_v[win];
               out_vld_d = 1'b1;
               grant_d   = win;
               state_d   = SEND;
            end
         end
         SEND: begin
            if (bus.out_rdy) begin
               out_vld_d = 1'b0;
               ack_d     = 4'b0001 << grant_q;
               last_d    = grant_q;
               state_d   = ACK;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         last_q    <= 2'd3;
         grant_q   <= 2'd0;
         ack_q     <= '0;
         out_vld_q <= 1'b0;
         out_dat_q <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         grant_q   <= grant_d;
         ack_q     <= ack_d;
         out_vld_q <= out_vld_d;
         out_dat_q <= out_dat_d;
      end
   end

   assign bus.ack0    = ack_q[0];
   assign bus.ack1    = ack_q[1];
   assign bus.ack2    = ack_q[2];
   assign bus.ack3    = ack_q[3];
   assign bus.out_vld = out_vld_q;
   assign bus.out_dat = out_dat_q;
endmodule

// File: tb/tb_sw_outarb.sv
// Bench for sw_outarb: directed scenarios plus a randomized run, all checked against a transaction-level model.
module tb_sw_outarb;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req = '0;
   logic [31:0] dat [4];
   logic        rdy = 1'b0;
   logic [3:0]  ack_v;
   logic        rnd = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   sw_outarb_if #(.DW(32)) bus ();

   assign bus.req0    = req[0];
   assign bus.req1    = req[1];
   assign bus.req2    = req[2];
   assign bus.req3    = req[3];
   assign bus.dat0    = dat[0];
   assign bus.dat1    = dat[1];
   assign bus.dat2    = dat[2];
   assign bus.dat3    = dat[3];
   assign bus.out_rdy = rdy;
   assign ack_v       = {bus.ack3, bus.ack2, bus.ack1, bus.ack0};

   sw_outarb #(.DW(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: a word is either absent, offered, or just acknowledged.
   logic        m_vld = 1'b0;
   logic [31:0] m_dat = '0;
   logic [3:0]  m_ack = '0;
   int          m_last = 3;
   int          m_g = 0;
   int          m_grants[$];
   int          wait_n[4];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_vld  = 1'b0;
         m_dat  = '0;
         m_ack  = '0;
         m_last = 3;
         for (int i = 0; i < 4; i++) wait_n[i] = 0;
      end else begin
         for (int i = 0; i < 4; i++) if (!req[i]) wait_n[i] = 0;
         if (m_ack != 0) begin
            m_ack = '0;
         end else if (m_vld) begin
            if (rdy) begin
               m_vld  = 1'b0;
               m_ack  = 4'(1 << m_g);
               m_last = m_g;
            end
         end else if (req != 0) begin
            m_g = -1;
            for (int k = 1; k <= 4; k++)
               if (m_g < 0 && req[(m_last + k) % 4]) m_g = (m_last + k) % 4;
            m_vld = 1'b1;
            m_dat = dat[m_g];
            m_grants.push_back(m_g);
            for (int i = 0; i < 4; i++) begin
               if (i == m_g) wait_n[i] = 0;
               else if (req[i]) begin
                  wait_n[i]++;
                  chk("starvation", 32'(wait_n[i] <= 3), 32'd1);
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("out_vld", 32'(bus.out_vld), 32'(m_vld));
      chk("out_dat", bus.out_dat, m_dat);
      chk("ack", 32'(ack_v), 32'(m_ack));
      chk("ack_onehot", 32'($countones(ack_v) <= 1), 32'd1);
   end

   logic [31:0] cap_q[$];

   // Requesters drop req on seeing their ack; in random mode they also raise/drop at will.
   task automatic tick();
      if (bus.out_vld && rdy) cap_q.push_back(bus.out_dat);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         if (ack_v[i]) req[i] = 1'b0;
         else if (rnd) begin
            if (!req[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  req[i] = 1'b1;
                  dat[i] = $urandom;
               end
            end else if ($urandom_range(0, 63) == 0) req[i] = 1'b0;
         end
      end
      if (rnd) rdy = ($urandom_range(0, 3) != 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req = '0;
      rdy = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 4; i++) dat[i] = '0;
      #1;
      chk("reset_vld", 32'(bus.out_vld), 32'd0);
      chk("reset_dat", bus.out_dat, 32'd0);
      chk("reset_ack", 32'(ack_v), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // 1: single request from port 0
      req[0] = 1'b1; dat[0] = 32'hA5A5_0000; rdy = 1'b1;
      tick();
      chk("t1_vld", 32'(bus.out_vld), 32'd1);
      chk("t1_dat", bus.out_dat, 32'hA5A5_0000);
      chk("t1_noack", 32'(ack_v), 32'd0);
      tick();
      chk("t1_ack", 32'(ack_v), 32'b0001);
      chk("t1_vld_low", 32'(bus.out_vld), 32'd0);
      tick();
      chk("t1_ack_end", 32'(ack_v), 32'd0);

      // 2: all ports requesting continuously
      do_reset();
      cap_q.delete();
      m_grants.delete();
      for (int i = 0; i < 4; i++) dat[i] = 32'(i);
      req = 4'hF; rdy = 1'b1;
      repeat (16) begin
         tick();
         for (int i = 0; i < 4; i++) if (!ack_v[i]) req[i] = 1'b1;
      end
      chk("t2_count", 32'(cap_q.size() >= 5), 32'd1);
      chk("t2_grants", 32'(m_grants.size() >= 5), 32'd1);
      if (cap_q.size() >= 5 && m_grants.size() >= 5) begin
         chk("t2_d0", cap_q[0], 32'd0);
         chk("t2_d1", cap_q[1], 32'd1);
         chk("t2_d2", cap_q[2], 32'd2);
         chk("t2_d3", cap_q[3], 32'd3);
         chk("t2_d4", cap_q[4], 32'd0);
         chk("t2_g1", 32'(m_grants[1]), 32'd1);
         chk("t2_g4", 32'(m_grants[4]), 32'd0);
      end

      // 3: sink stalls for 5 cycles
      do_reset();
      req[2] = 1'b1; dat[2] = 32'h2222_CAFE; rdy = 1'b0;
      tick();
      repeat (5) begin
         chk("t3_hold_vld", 32'(bus.out_vld), 32'd1);
         chk("t3_hold_dat", bus.out_dat, 32'h2222_CAFE);
         chk("t3_hold_ack", 32'(ack_v), 32'd0);
         tick();
      end
      rdy = 1'b1;
      tick();
      chk("t3_ack", 32'(ack_v), 32'b0100);
      tick();
      chk("t3_ack_end", 32'(ack_v), 32'd0);

      // 4: granted port withdraws during SEND
      do_reset();
      cap_q.delete();
      req[1] = 1'b1; dat[1] = 32'h1111_0001; rdy = 1'b0;
      tick();
      req[1] = 1'b0;
      tick();
      chk("t4_vld", 32'(bus.out_vld), 32'd1);
      rdy = 1'b1;
      tick();
      chk("t4_ack", 32'(ack_v), 32'b0010);
      chk("t4_delivered", 32'(cap_q.size()), 32'd1);
      if (cap_q.size() == 1) chk("t4_word", cap_q[0], 32'h1111_0001);
      tick();
      chk("t4_ack_end", 32'(ack_v), 32'd0);

      // 5: reset in the middle of SEND
      do_reset();
      req[1] = 1'b1; dat[1] = 32'h0BAD_0BAD; rdy = 1'b0;
      tick();
      chk("t5_send", 32'(bus.out_vld), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_vld", 32'(bus.out_vld), 32'd0);
      chk("t5_rst_ack", 32'(ack_v), 32'd0);
      chk("t5_rst_dat", bus.out_dat, 32'd0);
      req = '0;
      rdy = 1'b1;
      repeat (2) @(negedge clk);
      chk("t5_noack", 32'(ack_v), 32'd0);
      req[3] = 1'b1; dat[3] = 32'h3333_0003; rdy = 1'b0;
      rst = 1'b0;
      tick();
      chk("t5_dat3", bus.out_dat, 32'h3333_0003);
      chk("t5_model_g3", 32'(m_grants[$]), 32'd3);
      chk("t5_noack2", 32'(ack_v), 32'd0);
      rdy = 1'b1;
      tick();
      chk("t5_ack3", 32'(ack_v), 32'b1000);
      tick();

      // 6: randomized traffic checked every cycle by the model
      rnd = 1'b1;
      repeat (1000) tick();
      rnd = 1'b0;
      req = '0;
      repeat (4) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
